// File: rtl/act_mem_port_arbiter_pkg.sv
// rtl/act_mem_port_arbiter_pkg.sv - shared types and constants for the activation-memory port arbiter
package act_mem_port_arbiter_pkg;

   // FSM states: internal-priority mode and external burst mode
   typedef enum logic {
      S_INT = 1'b0,
      S_EXT = 1'b1
   } arb_state_t;

   // Which single transaction reaches the memory this cycle
   typedef enum logic [1:0] {
      WIN_NONE   = 2'd0,
      WIN_EXT    = 2'd1,
      WIN_INT_WR = 2'd2,
      WIN_INT_RD = 2'd3
   } arb_win_t;

   // ACT memory geometry: word index, lane select and block-column select bits
   localparam int ACT_WORD_BITS    = 7;
   localparam int ACT_LANE_BITS    = 2;
   localparam int ACT_BLK_COL_BITS = 1;
   localparam int ACT_ADDR_W       = ACT_WORD_BITS + ACT_LANE_BITS + ACT_BLK_COL_BITS;
   localparam int ACT_N_LANES      = 4;
   localparam int ACT_DATA_W       = 8;

   // External fairness: longest tolerated wait and beats granted once it is reached
   localparam int ACT_ARB_MAX_WAIT  = 4;
   localparam int ACT_ARB_EXT_BURST = 2;

endpackage

// File: rtl/act_mem_port_arbiter.sv
// rtl/act_mem_port_arbiter.sv - single-port arbiter between external and MAC-engine requesters of the activation memory
module act_mem_port_arbiter
   import act_mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W    = ACT_ADDR_W,
   parameter int N_LANES   = ACT_N_LANES,
   parameter int DATA_W    = ACT_DATA_W,
   parameter int MAX_WAIT  = ACT_ARB_MAX_WAIT,
   parameter int EXT_BURST = ACT_ARB_EXT_BURST
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        ext_req,
   input  logic                        ext_we,
   input  logic [ADDR_W-1:0]           ext_addr,
   input  logic [N_LANES*DATA_W-1:0]   ext_wdata,
   output logic                        ext_gnt,
   output logic                        ext_rvalid,
   input  logic                        int_rd_req,
   input  logic [ADDR_W-1:0]           int_rd_addr,
   input  logic                        int_wr_req,
   input  logic [ADDR_W-1:0]           int_wr_addr,
   input  logic [N_LANES*DATA_W-1:0]   int_wr_data,
   output logic                        int_stall,
   output logic                        int_rvalid,
   output logic                        mem_rd_enable,
   output logic                        mem_wr_enable,
   output logic                        mem_rd_enable_ext,
   output logic                        mem_wr_enable_ext,
   output logic [ADDR_W-1:0]           mem_rd_addr,
   output logic [ADDR_W-1:0]           mem_wr_addr,
   output logic [ADDR_W-1:0]           mem_rd_addr_ext,
   output logic [ADDR_W-1:0]           mem_wr_addr_ext,
   output logic [N_LANES*DATA_W-1:0]   mem_wr_data,
   output logic [N_LANES*DATA_W-1:0]   mem_wr_data_ext
);

   localparam int ROW_W   = N_LANES * DATA_W;
   localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
   localparam int BURST_W = $clog2(EXT_BURST + 1);

   localparam logic [WAIT_W-1:0]  WAIT_SAT     = WAIT_W'(MAX_WAIT);
   localparam logic [WAIT_W-1:0]  WAIT_ONE     = WAIT_W'(1);
   localparam logic [BURST_W-1:0] BURST_RELOAD = BURST_W'(EXT_BURST - 1);
   localparam logic [BURST_W-1:0] BURST_ONE    = BURST_W'(1);

   arb_state_t         state_q, state_d;
   logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
   logic               ext_rvalid_q, int_rvalid_q;
   arb_win_t           win;
   logic               starved;

   // External has waited the maximum number of cycles and must win now
   assign starved = ext_req && (wait_cnt_q == WAIT_SAT);

   // State register: FSM, fairness counters and read-valid strobes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_INT;
         wait_cnt_q   <= '0;
         burst_cnt_q  <= '0;
         ext_rvalid_q <= 1'b0;
         int_rvalid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         burst_cnt_q  <= burst_cnt_d;
         ext_rvalid_q <= (win == WIN_EXT) && !ext_we;
         int_rvalid_q <= (win == WIN_INT_RD);
      end
   end

   // Next state: enter a burst on starvation, leave when beats run out or ext goes idle
   always_comb begin
      state_d     = state_q;
      burst_cnt_d = burst_cnt_q;
      case (state_q)
         S_INT: begin
            if (starved && (EXT_BURST > 1)) begin
               state_d     = S_EXT;
               burst_cnt_d = BURST_RELOAD;
            end
         end
         S_EXT: begin
            if (!ext_req || (burst_cnt_q <= BURST_ONE)) begin
               state_d     = S_INT;
               burst_cnt_d = '0;
            end else begin
               burst_cnt_d = burst_cnt_q - BURST_ONE;
            end
         end
         default: begin
            state_d     = S_INT;
            burst_cnt_d = '0;
         end
      endcase
   end

   // Winner selection: ext first in a burst or when starved, else write, read, ext
   always_comb begin
      win = WIN_NONE;
      if (ext_req && ((state_q == S_EXT) || starved)) begin
         win = WIN_EXT;
      end else if (int_wr_req) begin
         win = WIN_INT_WR;
      end else if (int_rd_req) begin
         win = WIN_INT_RD;
      end else if (ext_req) begin
         win = WIN_EXT;
      end
   end

   // Wait counter: count ungranted ext cycles, saturating; clear on grant or idle
   always_comb begin
      wait_cnt_d = '0;
      if (ext_req && (win != WIN_EXT)) begin
         wait_cnt_d = (wait_cnt_q == WAIT_SAT) ? wait_cnt_q : (wait_cnt_q + WAIT_ONE);
      end
   end

   // Memory-side enables and pass-through buses, zeroed when not enabled
   always_comb begin
      ext_gnt           = (win == WIN_EXT);
      mem_rd_enable     = (win == WIN_INT_RD);
      mem_wr_enable     = (win == WIN_INT_WR);
      mem_rd_enable_ext = (win == WIN_EXT) && !ext_we;
      mem_wr_enable_ext = (win == WIN_EXT) && ext_we;
      int_stall         = (int_wr_req && (win != WIN_INT_WR)) ||
                          (int_rd_req && (win != WIN_INT_RD));
      mem_rd_addr       = mem_rd_enable     ? int_rd_addr : '0;
      mem_wr_addr       = mem_wr_enable     ? int_wr_addr : '0;
      mem_wr_data       = mem_wr_enable     ? int_wr_data : {ROW_W{1'b0}};
      mem_rd_addr_ext   = mem_rd_enable_ext ? ext_addr    : '0;
      mem_wr_addr_ext   = mem_wr_enable_ext ? ext_addr    : '0;
      mem_wr_data_ext   = mem_wr_enable_ext ? ext_wdata   : {ROW_W{1'b0}};
   end

   assign ext_rvalid = ext_rvalid_q;
   assign int_rvalid = int_rvalid_q;

endmodule

// File: tb/tb_act_mem_port_arbiter.sv
// tb/tb_act_mem_port_arbiter.sv - self-checking bench for act_mem_port_arbiter
module tb_act_mem_port_arbiter;
   import act_mem_port_arbiter_pkg::*;

   localparam int AW = 10;
   localparam int WD = 32;
   localparam int MW = 4;
   localparam int EB = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          ext_req, ext_we, ext_gnt, ext_rvalid;
   logic [AW-1:0] ext_addr;
   logic [WD-1:0] ext_wdata;
   logic          int_rd_req, int_wr_req, int_stall, int_rvalid;
   logic [AW-1:0] int_rd_addr, int_wr_addr;
   logic [WD-1:0] int_wr_data;
   logic          mem_rd_enable, mem_wr_enable, mem_rd_enable_ext, mem_wr_enable_ext;
   logic [AW-1:0] mem_rd_addr, mem_wr_addr, mem_rd_addr_ext, mem_wr_addr_ext;
   logic [WD-1:0] mem_wr_data, mem_wr_data_ext;

   act_mem_port_arbiter #(
      .ADDR_W(AW), .N_LANES(4), .DATA_W(8), .MAX_WAIT(MW), .EXT_BURST(EB)
   ) dut (
      .clk(clk), .reset(reset),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid),
      .int_rd_req(int_rd_req), .int_rd_addr(int_rd_addr),
      .int_wr_req(int_wr_req), .int_wr_addr(int_wr_addr), .int_wr_data(int_wr_data),
      .int_stall(int_stall), .int_rvalid(int_rvalid),
      .mem_rd_enable(mem_rd_enable), .mem_wr_enable(mem_wr_enable),
      .mem_rd_enable_ext(mem_rd_enable_ext), .mem_wr_enable_ext(mem_wr_enable_ext),
      .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr),
      .mem_rd_addr_ext(mem_rd_addr_ext), .mem_wr_addr_ext(mem_wr_addr_ext),
      .mem_wr_data(mem_wr_data), .mem_wr_data_ext(mem_wr_data_ext)
   );

   always #5 clk = ~clk;

   // Simple SRAM with 1-cycle read latency, write visible to the next cycle's read
   logic [WD-1:0] tb_mem [0:(1<<AW)-1];
   logic [WD-1:0] rd_data;
   always @(posedge clk) begin
      if (mem_wr_enable)     tb_mem[mem_wr_addr]     <= mem_wr_data;
      if (mem_wr_enable_ext) tb_mem[mem_wr_addr_ext] <= mem_wr_data_ext;
      if (mem_rd_enable)     rd_data <= tb_mem[mem_rd_addr];
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clr_in();
      ext_req     = 1'b0;  ext_we      = 1'b0;
      int_rd_req  = 1'b0;  int_wr_req  = 1'b0;
      ext_addr    = 10'h005; int_rd_addr = 10'h010; int_wr_addr = 10'h020;
      ext_wdata   = 32'hA5A5_0001; int_wr_data = 32'h1234_5678;
   endtask

   task automatic do_reset();
      clr_in();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic er, ew, ir, iw;
      logic gnt;
      logic [3:0] en;   // {rd, wr, rd_ext, wr_ext}
      logic stall, erv, irv;
   } vec_t;

   vec_t tbl [8];

   // reference model state for the random phase
   int   m_wait, m_burst, win;
   logic m_erv, m_irv;
   logic [109:0] act_v, exp_v;
   logic e_gnt, e_rd, e_wr, e_rde, e_wre, e_stall;
   logic [7:0] pat_gnt, pat_rv;

   initial begin
      tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b1};
      tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0};
      tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b1};
      tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0};

      // reset state
      do_reset();
      @(negedge clk);
      chk("reset_rvalid", {ext_rvalid, int_rvalid}, 2'b00);
      chk("reset_outs", {ext_gnt, mem_rd_enable, mem_wr_enable, mem_rd_enable_ext,
                         mem_wr_enable_ext, int_stall, mem_rd_addr, mem_wr_addr,
                         mem_rd_addr_ext, mem_wr_addr_ext, mem_wr_data, mem_wr_data_ext}, '0);

      // single-cycle vectors from a fresh reset
      for (int i = 0; i < 8; i++) begin
         do_reset();
         ext_req = tbl[i].er; ext_we = tbl[i].ew;
         int_rd_req = tbl[i].ir; int_wr_req = tbl[i].iw;
         @(negedge clk);
         chk($sformatf("tbl%0d_gnt", i), ext_gnt, tbl[i].gnt);
         chk($sformatf("tbl%0d_en", i),
             {mem_rd_enable, mem_wr_enable, mem_rd_enable_ext, mem_wr_enable_ext}, tbl[i].en);
         chk($sformatf("tbl%0d_stall", i), int_stall, tbl[i].stall);
         chk($sformatf("tbl%0d_addr", i),
             {mem_rd_addr, mem_wr_addr, mem_rd_addr_ext, mem_wr_addr_ext},
             {tbl[i].en[3] ? 10'h010 : 10'h0, tbl[i].en[2] ? 10'h020 : 10'h0,
              tbl[i].en[1] ? 10'h005 : 10'h0, tbl[i].en[0] ? 10'h005 : 10'h0});
         chk($sformatf("tbl%0d_data", i), {mem_wr_data, mem_wr_data_ext},
             {tbl[i].en[2] ? 32'h1234_5678 : 32'h0, tbl[i].en[0] ? 32'hA5A5_0001 : 32'h0});
         next_cycle();
         clr_in();
         @(negedge clk);
         chk($sformatf("tbl%0d_rvalid", i), {ext_rvalid, int_rvalid}, {tbl[i].erv, tbl[i].irv});
         next_cycle();
         chk($sformatf("tbl%0d_rvalid_once", i), {ext_rvalid, int_rvalid}, 2'b00);
      end

      // starvation: int read every cycle, ext write from cycle 0 to 5
      do_reset();
      pat_gnt = 8'b0011_0000;
      pat_rv  = 8'b1001_1110;
      for (int c = 0; c < 8; c++) begin
         int_rd_req = 1'b1;
         ext_req    = (c <= 5);
         ext_we     = 1'b1;
         @(negedge clk);
         chk($sformatf("starve_gnt_c%0d", c), ext_gnt, pat_gnt[c]);
         chk($sformatf("starve_wren_c%0d", c), mem_wr_enable_ext, pat_gnt[c]);
         chk($sformatf("starve_stall_c%0d", c), int_stall, pat_gnt[c]);
         chk($sformatf("starve_irv_c%0d", c), int_rvalid, pat_rv[c]);
         next_cycle();
      end

      // write then read the same address
      do_reset();
      int_wr_req = 1'b1; int_wr_addr = 10'h003; int_wr_data = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("wr_then_rd_wren", {mem_wr_enable, mem_wr_addr}, {1'b1, 10'h003});
      next_cycle();
      int_wr_req = 1'b0; int_rd_req = 1'b1; int_rd_addr = 10'h003;
      @(negedge clk);
      chk("wr_then_rd_rden", {mem_rd_enable, mem_rd_addr}, {1'b1, 10'h003});
      next_cycle();
      clr_in();
      @(negedge clk);
      chk("wr_then_rd_rvalid", int_rvalid, 1'b1);
      chk("wr_then_rd_data", rd_data, 32'hDEAD_BEEF);

      // ext request dropped before grant clears the wait count
      do_reset();
      for (int c = 0; c < 8; c++) begin
         int_rd_req = 1'b1;
         ext_req    = (c != 2);
         ext_we     = 1'b0;
         @(negedge clk);
         chk($sformatf("drop_gnt_c%0d", c), ext_gnt, (c == 7));
         next_cycle();
      end
      clr_in();

      // reset pulsed right after an external read grant inside a burst
      do_reset();
      for (int c = 0; c < 5; c++) begin
         int_rd_req = 1'b1; ext_req = 1'b1; ext_we = 1'b0;
         @(negedge clk);
         if (c == 4) chk("rst_pre_gnt", ext_gnt, 1'b1);
         next_cycle();
      end
      chk("rst_pre_rvalid", ext_rvalid, 1'b1);
      clr_in();
      reset = 1'b0;
      #1;
      chk("rst_async_rvalid", {ext_rvalid, int_rvalid}, 2'b00);
      @(negedge clk);
      chk("rst_enables", {mem_rd_enable, mem_wr_enable, mem_rd_enable_ext, mem_wr_enable_ext, ext_gnt}, 5'b0);
      next_cycle();
      chk("rst_hold_rvalid", {ext_rvalid, int_rvalid}, 2'b00);
      reset = 1'b1;
      int_rd_req = 1'b1; ext_req = 1'b1; ext_we = 1'b0;
      @(negedge clk);
      chk("rst_after_rvalid", {ext_rvalid, int_rvalid}, 2'b00);
      chk("rst_fsm_int", {ext_gnt, mem_rd_enable}, 2'b01);
      next_cycle();
      clr_in();
      @(negedge clk);
      chk("rst_after_rvalid2", {ext_rvalid, int_rvalid}, 2'b01);

      // randomized traffic against the reference model
      do_reset();
      m_wait = 0; m_burst = 0; m_erv = 1'b0; m_irv = 1'b0;
      for (int n = 0; n < 2000; n++) begin
         ext_req     = ($urandom_range(0, 9) < 6);
         ext_we      = $urandom_range(0, 1) == 1;
         int_rd_req  = ($urandom_range(0, 9) < 5);
         int_wr_req  = ($urandom_range(0, 9) < 3);
         ext_addr    = AW'($urandom);
         int_rd_addr = AW'($urandom);
         int_wr_addr = AW'($urandom);
         ext_wdata   = $urandom;
         int_wr_data = $urandom;
         @(negedge clk);
         if (ext_req && (m_burst > 0 || m_wait >= MW)) win = 1;
         else if (int_wr_req) win = 2;
         else if (int_rd_req) win = 3;
         else if (ext_req) win = 1;
         else win = 0;
         e_gnt   = (win == 1);
         e_rd    = (win == 3);
         e_wr    = (win == 2);
         e_rde   = e_gnt && !ext_we;
         e_wre   = e_gnt && ext_we;
         e_stall = (int_wr_req && !e_wr) || (int_rd_req && !e_rd);
         exp_v = {e_gnt, e_rd, e_wr, e_rde, e_wre, e_stall,
                  e_rd ? int_rd_addr : 10'h0, e_wr ? int_wr_addr : 10'h0,
                  e_rde ? ext_addr : 10'h0, e_wre ? ext_addr : 10'h0,
                  e_wr ? int_wr_data : 32'h0, e_wre ? ext_wdata : 32'h0};
         act_v = {ext_gnt, mem_rd_enable, mem_wr_enable, mem_rd_enable_ext, mem_wr_enable_ext,
                  int_stall, mem_rd_addr, mem_wr_addr, mem_rd_addr_ext, mem_wr_addr_ext,
                  mem_wr_data, mem_wr_data_ext};
         chk($sformatf("rand%0d_outs", n), act_v, exp_v);
         chk($sformatf("rand%0d_rvalid", n), {ext_rvalid, int_rvalid}, {m_erv, m_irv});
         m_erv = e_rde;
         m_irv = e_rd;
         if (e_gnt) begin
            if (m_burst > 0) m_burst = m_burst - 1;
            else if (m_wait >= MW) m_burst = EB - 1;
            m_wait = 0;
         end else if (ext_req) begin
            m_wait = (m_wait < MW) ? m_wait + 1 : MW;
         end else begin
            m_wait  = 0;
            m_burst = 0;
         end
         next_cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
